voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphonic note scheduler in front of NUM_VOICES oscillator instances.
//  Accepts note-on/note-off requests from the CPU register bridge and assigns
//  each to a voice. Priority: retrigger a voice already playing the same note,
//  else take a free voice, else steal the oldest.
//  Drives per-voice increment, voice_select, gate and trigger into the
//  oscillator/envelope bank.
// PARAMETERS
//  NUM_VOICES  4   voices managed; >=2
//  INC_WIDTH   21  oscillator phase increment width
//  NOTE_WIDTH  7   note number width (MIDI range)
//  AGE_WIDTH   4   per-voice age counter width, saturating
// PORTS
//  clk              in   1                       system clock
//  rst              in   1                       sync reset, active-high
//  req_valid        in   1                       request present
//  req_ready        out  1                       high only in IDLE
//  req_on           in   1                       1=note-on, 0=note-off
//  req_note         in   NOTE_WIDTH              note number
//  req_increment    in   INC_WIDTH               increment for note-on
//  req_voice_sel    in   4                       waveform mix for note-on
//  panic            in   1                       all-notes-off
//  voice_increment  out  NUM_VOICES*INC_WIDTH    voice v at [v*INC_WIDTH +: INC_WIDTH]
//  voice_select     out  NUM_VOICES*4            voice v at [v*4 +: 4]
//  voice_gate       out  NUM_VOICES              1=voice sounding
//  voice_trigger    out  NUM_VOICES              1-cycle pulse on note-on commit
//  alloc_valid      out  1                       1-cycle pulse, request finished
//  alloc_voice      out  $clog2(NUM_VOICES)      voice acted on
//  alloc_hit        out  1                       note-off found a match
//  alloc_stole      out  1                       note-on stole a gated voice
// BEHAVIOUR
//  Reset: all outputs 0; per-voice note and age registers 0.
//    FSM enters IDLE; req_ready=1 on the first cycle after rst deasserts.
//  FSM: IDLE -> SCAN -> COMMIT -> IDLE.
//  - IDLE: req_valid&req_ready at edge E0 latches req_*; idx=0; go SCAN.
//  - SCAN: one voice per edge (E1..EN); record first same-note gated voice,
//    first non-gated voice, and max-age gated voice (ties: lowest index).
//    After idx==NUM_VOICES-1, go COMMIT.
//  - COMMIT (edge EN+1): write voice regs, pulse alloc_valid, go IDLE.
//  Latency: results visible N+1 cycles after accept. Min request period N+2.
//  Note-on, target chosen in priority order:
//    1. same-note gated voice: alloc_stole=0.
//    2. lowest-index free voice: alloc_stole=0.
//    3. oldest gated voice: alloc_stole=1.
//    Target: increment<=req_increment, select<=req_voice_sel, note<=req_note,
//    gate<=1, trigger pulse, age<=0. Every other voice: age+1, saturating
//    at 2^AGE_WIDTH-1. alloc_hit=1.
//  Note-off: first gated voice with matching note gets gate<=0.
//    Increment, select and note are held for the release tail. alloc_hit=1.
//    No match: no state change; alloc_hit=0; alloc_voice=0; alloc_valid
//    still pulses.
//  Scan state is registered at E0. voice_* cannot change during SCAN
//    (single writer).
//  panic (any state): next edge clears all gates, triggers and ages.
//    Pending request is dropped with no alloc_valid; FSM goes to IDLE.
//    If both panic and rst are asserted, rst wins.
//  rst mid-SCAN/COMMIT: request dropped, full reset state.
//  alloc_* fields hold their value until the next commit; only alloc_valid
//    and voice_trigger are pulses.
//  req_* inputs are ignored except at the accept edge.
// TESTING
//  (NUM_VOICES=4)
//  1. Reset, then on(60,inc=0x1000,sel=1): commit 5 cycles after accept.
//     voice0 gate=1, trigger pulse, alloc_voice=0, stole=0.
//  2. on 60,62,64,65 then on 67: 67 steals voice0 (stole=1, increment
//     updated); gate stays 1; trigger pulses.
//  3. on 60 twice: second request retriggers voice0; voice1 stays free;
//     voice0 age resets to 0.
//  4. off 62 with no voice on 62: alloc_valid=1, hit=0, gates unchanged.
//     off 60 after on 60: voice0 gate=0, increment still 0x1000.
//  5. panic asserted mid-SCAN: next cycle gates=0, no alloc_valid, ready=1.
//     rst asserted mid-SCAN: all outputs 0.
//  6. req_valid held high: accepts at E0 and E0+6 only; ready low between.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: scans all voices one per cycle, then commits a
// note-on (retrigger > free > steal oldest) or note-off to a single voice.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int INC_WIDTH  = 21,
  parameter int NOTE_WIDTH = 7,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_on,
  input  logic [NOTE_WIDTH-1:0]           req_note,
  input  logic [INC_WIDTH-1:0]            req_increment,
  input  logic [3:0]                      req_voice_sel,
  input  logic                            panic,
  output logic [NUM_VOICES*INC_WIDTH-1:0] voice_increment,
  output logic [NUM_VOICES*4-1:0]         voice_select,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES-1:0]           voice_trigger,
  output logic                            alloc_valid,
  output logic [$clog2(NUM_VOICES)-1:0]   alloc_voice,
  output logic                            alloc_hit,
  output logic                            alloc_stole
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;

  logic [VW-1:0]         idx;
  logic                  l_on;
  logic [NOTE_WIDTH-1:0] l_note;
  logic [INC_WIDTH-1:0]  l_inc;
  logic [3:0]            l_sel;

  logic                  same_found, free_found, old_found;
  logic [VW-1:0]         same_idx, free_idx, old_idx;
  logic [AGE_WIDTH-1:0]  old_age;

  logic [INC_WIDTH-1:0]  inc_r  [NUM_VOICES];
  logic [3:0]            sel_r  [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] note_r [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  age_r  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_r, trig_r;

  logic [VW-1:0] tgt;
  logic          tgt_hit, tgt_stole;

  // Resolve the commit target from the records gathered during SCAN.
  always_comb begin
    tgt       = '0;
    tgt_hit   = 1'b0;
    tgt_stole = 1'b0;
    if (l_on) begin
      tgt_hit = 1'b1;
      if (same_found)      tgt = same_idx;
      else if (free_found) tgt = free_idx;
      else begin
        tgt       = old_idx;
        tgt_stole = 1'b1;
      end
    end else if (same_found) begin
      tgt     = same_idx;
      tgt_hit = 1'b1;
    end
  end

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      l_on        <= 1'b0;
      l_note      <= '0;
      l_inc       <= '0;
      l_sel       <= '0;
      same_found  <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      same_idx    <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      gate_r      <= '0;
      trig_r      <= '0;
      alloc_valid <= 1'b0;
      alloc_voice <= '0;
      alloc_hit   <= 1'b0;
      alloc_stole <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        inc_r[v]  <= '0;
        sel_r[v]  <= '0;
        note_r[v] <= '0;
        age_r[v]  <= '0;
      end
    end else if (panic) begin
      state       <= IDLE;
      gate_r      <= '0;
      trig_r      <= '0;
      alloc_valid <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) age_r[v] <= '0;
    end else begin
      trig_r      <= '0;
      alloc_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          l_on       <= req_on;
          l_note     <= req_note;
          l_inc      <= req_increment;
          l_sel      <= req_voice_sel;
          idx        <= '0;
          same_found <= 1'b0;
          free_found <= 1'b0;
          old_found  <= 1'b0;
          same_idx   <= '0;
          free_idx   <= '0;
          old_idx    <= '0;
          old_age    <= '0;
          state      <= SCAN;
        end
        SCAN: begin
          if (gate_r[idx]) begin
            if (!same_found && note_r[idx] == l_note) begin
              same_found <= 1'b1;
              same_idx   <= idx;
            end
            // Strict compare keeps the lowest index on age ties.
            if (!old_found || age_r[idx] > old_age) begin
              old_found <= 1'b1;
              old_idx   <= idx;
              old_age   <= age_r[idx];
            end
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (idx == LAST) state <= COMMIT;
          else             idx   <= idx + 1'b1;
        end
        COMMIT: begin
          alloc_valid <= 1'b1;
          alloc_voice <= tgt;
          alloc_hit   <= tgt_hit;
          alloc_stole <= tgt_stole;
          if (l_on) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (VW'(v) == tgt) begin
                inc_r[v]  <= l_inc;
                sel_r[v]  <= l_sel;
                note_r[v] <= l_note;
                age_r[v]  <= '0;
                gate_r[v] <= 1'b1;
                trig_r[v] <= 1'b1;
              end else if (age_r[v] != AGE_MAX) begin
                age_r[v] <= age_r[v] + 1'b1;
              end
            end
          end else if (tgt_hit) begin
            // Note-off keeps increment/select for the release tail.
            gate_r[tgt] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign voice_increment[v*INC_WIDTH +: INC_WIDTH] = inc_r[v];
    assign voice_select[v*4 +: 4]                    = sel_r[v];
  end
  assign voice_gate    = gate_r;
  assign voice_trigger = trig_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: requests push expected commits into a
// queue, an independent monitor checks each alloc_valid pulse against it.
module tb_voice_allocator;
  localparam int NV = 4, IW = 21, NW = 7, AW = 4;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_on = 0, panic = 0;
  logic [NW-1:0] req_note = '0;
  logic [IW-1:0] req_increment = '0;
  logic [3:0] req_voice_sel = '0;
  logic [NV*IW-1:0] voice_increment;
  logic [NV*4-1:0] voice_select;
  logic [NV-1:0] voice_gate, voice_trigger;
  logic alloc_valid, alloc_hit, alloc_stole;
  logic [1:0] alloc_voice;

  voice_allocator #(.NUM_VOICES(NV), .INC_WIDTH(IW), .NOTE_WIDTH(NW), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_on(req_on),
    .req_note(req_note), .req_increment(req_increment), .req_voice_sel(req_voice_sel),
    .panic(panic), .voice_increment(voice_increment), .voice_select(voice_select),
    .voice_gate(voice_gate), .voice_trigger(voice_trigger), .alloc_valid(alloc_valid),
    .alloc_voice(alloc_voice), .alloc_hit(alloc_hit), .alloc_stole(alloc_stole));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] voice; logic hit, stole;
    logic [3:0] gate, trig; logic [IW-1:0] inc; int cyc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Monitor: every alloc_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && alloc_valid) begin
      if (exp_q.size() == 0) check("unexpected_alloc", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("alloc_cycle", cyc_cnt, e.cyc);
        check("alloc_voice", alloc_voice, e.voice);
        check("alloc_hit", alloc_hit, e.hit);
        check("alloc_stole", alloc_stole, e.stole);
        check("voice_gate", voice_gate, e.gate);
        check("voice_trigger", voice_trigger, e.trig);
        check("voice_inc", voice_increment[int'(alloc_voice)*IW +: IW], e.inc);
      end
    end
  end

  task automatic send(input bit on, input logic [NW-1:0] note, input logic [IW-1:0] inc,
                      input logic [3:0] sel, input bit chk, input logic [1:0] ev,
                      input bit eh, input bit es, input logic [3:0] eg, input logic [3:0] et,
                      input logic [IW-1:0] einc);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1; req_on = on; req_note = note; req_increment = inc; req_voice_sel = sel;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 0;
    if (chk) begin
      e.voice = ev; e.hit = eh; e.stole = es; e.gate = eg; e.trig = et; e.inc = einc;
      e.cyc = cyc_cnt + 5;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_gate", voice_gate, 0);
    check("rst_inc", voice_increment, 0);
    check("rst_valid", alloc_valid, 0);
    check("rst_ready_low", req_ready, 0);
    rst = 0; #1;
    check("ready_after_rst", req_ready, 1);

    // 1: first note-on lands on voice 0
    send(1, 60, 21'h1000, 1, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h1000);
    drain();
    check("sel_v0", voice_select[3:0], 1);

    // 2: fill all voices, then steal the oldest (voice 0)
    do_reset();
    send(1, 60, 21'h0100, 0, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h0100);
    send(1, 62, 21'h0200, 0, 1, 1, 1, 0, 4'b0011, 4'b0010, 21'h0200);
    send(1, 64, 21'h0300, 0, 1, 2, 1, 0, 4'b0111, 4'b0100, 21'h0300);
    send(1, 65, 21'h0400, 0, 1, 3, 1, 0, 4'b1111, 4'b1000, 21'h0400);
    send(1, 67, 21'h2222, 5, 1, 0, 1, 1, 4'b1111, 4'b0001, 21'h2222);
    drain();

    // 3: retrigger reuses voice 0; retrigger also resets its age, so the later steal hits voice 1
    do_reset();
    send(1, 60, 21'h1000, 0, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h1000);
    send(1, 60, 21'h1111, 0, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h1111);
    send(1, 61, 21'h1200, 0, 1, 1, 1, 0, 4'b0011, 4'b0010, 21'h1200);
    send(1, 60, 21'h1300, 0, 1, 0, 1, 0, 4'b0011, 4'b0001, 21'h1300);
    send(1, 62, 21'h1400, 0, 1, 2, 1, 0, 4'b0111, 4'b0100, 21'h1400);
    send(1, 63, 21'h1500, 0, 1, 3, 1, 0, 4'b1111, 4'b1000, 21'h1500);
    send(1, 64, 21'h1600, 0, 1, 1, 1, 1, 4'b1111, 4'b0010, 21'h1600);
    drain();

    // 4: note-off without and with a match
    do_reset();
    send(0, 62, 21'h0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 21'h0);
    send(1, 60, 21'h1000, 3, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h1000);
    send(0, 60, 21'h0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 21'h1000);
    drain();
    check("off_keeps_sel", voice_select[3:0], 3);

    // 5a: panic mid-SCAN drops the request and clears gates
    do_reset();
    send(1, 62, 21'h0AAA, 2, 1, 0, 1, 0, 4'b0001, 4'b0001, 21'h0AAA);
    drain();
    send(1, 60, 21'h0BBB, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); panic = 1;
    @(negedge clk); panic = 0;
    check("panic_gate", voice_gate, 0);
    check("panic_trig", voice_trigger, 0);
    check("panic_valid", alloc_valid, 0);
    check("panic_ready", req_ready, 1);
    repeat (10) @(negedge clk);

    // 5b: reset mid-SCAN clears everything
    send(1, 64, 21'h0CCC, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    check("rstmid_gate", voice_gate, 0);
    check("rstmid_inc", voice_increment, 0);
    check("rstmid_sel", voice_select, 0);
    check("rstmid_trig", voice_trigger, 0);
    check("rstmid_valid", alloc_valid, 0);
    check("rstmid_hit", alloc_hit, 0);
    check("rstmid_ready", req_ready, 0);
    rst = 0; #1;
    check("rstmid_ready_after", req_ready, 1);

    // 6: req_valid held high: accepts only every 6 cycles
    @(negedge clk);
    req_valid = 1; req_on = 1; req_note = 70; req_increment = 21'h0777; req_voice_sel = 2;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check("held_ready", req_ready, (k == 0 || k == 6));
      if (req_ready) begin
        exp_t e;
        e.voice = 0; e.hit = 1; e.stole = 0; e.gate = 4'b0001; e.trig = 4'b0001;
        e.inc = 21'h0777; e.cyc = cyc_cnt + 6;
        exp_q.push_back(e);
      end
    end
    req_valid = 0;
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
